// File: rtl/seg_refresh_ctrl.sv
// Purpose: arbitrates two 64-bit frame requesters onto a serial shifter and periodically re-sends the held frame.
// Latency: request sampled in IDLE on cycle N gives start/ack on cycle N+1; transfer ends one cycle after done or timeout.
// Backpressure: requests are level-held until acked; while busy they stay pending and are arbitrated in the first IDLE cycle.
module seg_refresh_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000000,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [63:0] data_a,
    input  logic        req_b,
    input  logic [63:0] data_b,
    input  logic        done,
    output logic [63:0] p_data,
    output logic        start,
    output logic        ack_a,
    output logic        ack_b,
    output logic        busy,
    output logic        src,
    output logic        timeout_err
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [RW-1:0] refresh_cnt;
    logic [WW-1:0] wait_cnt;
    logic          last_b;      // 1 when the most recent request grant went to B
    logic          grant_a;
    logic          grant_b;
    logic          refresh_hit;
    logic          wait_hit;

    // Round-robin grant: a lone request wins, a contested one goes to whoever was not served last.
    always_comb begin
        grant_a     = req_a && (!req_b || last_b);
        grant_b     = req_b && !grant_a;
        refresh_hit = (refresh_cnt == REFRESH_LAST);
        wait_hit    = (wait_cnt == WAIT_LAST);
    end

    // Transfer FSM with registered outputs; start/ack are one-cycle pulses asserted while in LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            p_data      <= '0;
            src         <= 1'b0;
            start       <= 1'b0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            refresh_cnt <= '0;
            wait_cnt    <= '0;
            last_b      <= 1'b1;
        end else begin
            start <= 1'b0;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        // A real request always beats a refresh expiring in the same cycle.
                        state       <= LOAD;
                        busy        <= 1'b1;
                        start       <= 1'b1;
                        ack_a       <= grant_a;
                        ack_b       <= grant_b;
                        p_data      <= grant_a ? data_a : data_b;
                        src         <= grant_b;
                        last_b      <= grant_b;
                        refresh_cnt <= '0;
                    end else if (refresh_hit) begin
                        // Re-send the held frame untouched; arbitration history is not disturbed.
                        state       <= LOAD;
                        busy        <= 1'b1;
                        start       <= 1'b1;
                        refresh_cnt <= '0;
                    end else begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (done) begin
                        // done wins over a coinciding timeout, so no error is flagged.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wait_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_refresh_ctrl.sv
// Purpose: scoreboard bench for seg_refresh_ctrl with a transaction-level reference model.
// Latency: expected frames are queued at issue time and popped whenever the DUT pulses start.
// Backpressure: requesters hold their request until acked; a shifter model answers start with done.
module tb_seg_refresh_ctrl;

    localparam int RDIV = 8;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a;
    logic [63:0] data_a;
    logic        req_b;
    logic [63:0] data_b;
    logic        done;
    logic        done_shift;
    logic        done_spur;
    logic [63:0] p_data;
    logic        start;
    logic        ack_a;
    logic        ack_b;
    logic        busy;
    logic        src;
    logic        timeout_err;

    assign done = done_shift | done_spur;

    always #5 clk = ~clk;

    seg_refresh_ctrl #(.REFRESH_DIV(RDIV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b),
        .done(done),
        .p_data(p_data), .start(start),
        .ack_a(ack_a), .ack_b(ack_b),
        .busy(busy), .src(src), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [63:0] data;
        logic        src;
        logic        aa;
        logic        ab;
        int          gap;   // idle cycles expected before start, -1 = not checked
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          idle_len = 0;
    int          shift_delay;
    bit          no_done;
    bit          exp_err;
    // Reference model: what has been sent and who was granted last.
    bit          m_last_b;
    logic [63:0] m_data;
    bit          m_src;

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic expect_xfer(input bit is_b, input logic [63:0] d, input int gap);
        exp_t e;
        e.data = d; e.src = is_b; e.aa = !is_b; e.ab = is_b; e.gap = gap;
        exp_q.push_back(e);
        m_last_b = is_b;
        m_data   = d;
        m_src    = is_b;
    endtask

    task automatic expect_refresh();
        exp_t e;
        e.data = m_data; e.src = m_src; e.aa = 1'b0; e.ab = 1'b0; e.gap = RDIV;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input bit is_b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_b ? ack_b : ack_a) return;
        end
        chk(1'b0, "ack_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk(1'b0, "idle_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (start) return;
        end
        chk(1'b0, "start_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic drop_req(input bit is_b);
        if (is_b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    // Called at a negedge of the first IDLE cycle (or any IDLE cycle for collision cases).
    task automatic do_single(input bit is_b, input logic [63:0] d, input int dly, input int gap);
        shift_delay = dly;
        if (is_b) begin data_b = d; req_b = 1'b1; end
        else      begin data_a = d; req_a = 1'b1; end
        expect_xfer(is_b, d, gap);
        wait_ack(is_b);
        drop_req(is_b);
        wait_idle();
    endtask

    task automatic do_both(input logic [63:0] da, input logic [63:0] db, input int dly);
        bit first_b;
        shift_delay = dly;
        data_a = da; data_b = db;
        req_a = 1'b1; req_b = 1'b1;
        first_b = !m_last_b;
        expect_xfer(first_b, first_b ? db : da, 1);
        expect_xfer(!first_b, first_b ? da : db, 1);
        wait_ack(first_b);
        drop_req(first_b);
        wait_ack(!first_b);
        drop_req(!first_b);
        wait_idle();
    endtask

    task automatic do_refresh(input int dly);
        shift_delay = dly;
        expect_refresh();
        repeat (3) @(negedge clk);
        done_spur = 1'b1;           // stray done while idle must be ignored
        @(negedge clk);
        done_spur = 1'b0;
        wait_start();
        wait_idle();
    endtask

    // Monitor: pops one expected frame per start pulse and checks the presented transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                idle_len = 0;
            end else begin
                if ((ack_a || ack_b) && !start)
                    chk(1'b0, "ack_without_start", {62'd0, ack_a, ack_b}, 64'd0);
                if (start) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_start", p_data, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(p_data == e.data, "p_data", p_data, e.data);
                        chk(src == e.src, "src", {63'd0, src}, {63'd0, e.src});
                        chk(ack_a == e.aa, "ack_a", {63'd0, ack_a}, {63'd0, e.aa});
                        chk(ack_b == e.ab, "ack_b", {63'd0, ack_b}, {63'd0, e.ab});
                        chk(busy == 1'b1, "busy_in_load", {63'd0, busy}, 64'd1);
                        if (e.gap >= 0)
                            chk(idle_len == e.gap, "idle_gap", 64'(idle_len), 64'(e.gap));
                    end
                    idle_len = 0;
                end else if (!busy) begin
                    idle_len++;
                end else begin
                    idle_len = 0;
                end
            end
        end
    end

    // Shifter model: answers start with a done pulse shift_delay cycles later.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst && start && !no_done) begin
                d = shift_delay;
                repeat (d) @(negedge clk);
                done_shift = 1'b1;
                chk(busy == 1'b1, "busy_at_done", {63'd0, busy}, 64'd1);
                @(negedge clk);
                done_shift = 1'b0;
                chk(busy == 1'b0, "busy_after_done", {63'd0, busy}, 64'd0);
                chk(timeout_err == exp_err, "timeout_err", {63'd0, timeout_err}, {63'd0, exp_err});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [63:0] d;
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        done_shift = 1'b0; done_spur = 1'b0; no_done = 1'b0; shift_delay = 1;
        exp_err = 1'b0; m_last_b = 1'b1; m_data = '0; m_src = 1'b0;

        repeat (2) @(negedge clk);
        chk({p_data, src, start, ack_a, ack_b, busy, timeout_err} == '0, "reset_outputs",
            {p_data[57:0], src, start, ack_a, ack_b, busy, timeout_err}, 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Contested requests out of reset: A, B, A, B.
        do_both(rnd64(), rnd64(), 3);
        do_both(rnd64(), rnd64(), 2);

        // Single A with a known frame, done five cycles after start.
        do_single(1'b0, 64'h0123_4567_89AB_CDEF, 5, 1);

        // Idle refresh re-sends the A frame.
        do_refresh(2);

        // done arriving in the very last WAIT cycle counts as done.
        do_single(1'b1, rnd64(), TMO, 1);

        // B arrives as the refresh counter expires: request wins, counter restarts.
        repeat (RDIV - 1) @(negedge clk);
        do_single(1'b1, rnd64(), 4, RDIV);
        do_refresh(1);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: do_single(1'b0, rnd64(), $urandom_range(1, TMO), 1);
                1: do_single(1'b1, rnd64(), $urandom_range(1, TMO), 1);
                2: do_both(rnd64(), rnd64(), $urandom_range(1, TMO));
                default: do_refresh($urandom_range(1, TMO));
            endcase
        end

        // Timeout: shifter never answers.
        chk(timeout_err == 1'b0, "no_timeout_yet", {63'd0, timeout_err}, 64'd0);
        no_done = 1'b1;
        d = rnd64();
        data_a = d; req_a = 1'b1;
        expect_xfer(1'b0, d, 1);
        wait_ack(1'b0);
        req_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk(cnt == TMO, "wait_cycles_to_timeout", 64'(cnt), 64'(TMO));
        chk(timeout_err == 1'b1, "timeout_err_set", {63'd0, timeout_err}, 64'd1);
        exp_err = 1'b1;
        no_done = 1'b0;
        do_single(1'b1, rnd64(), 3, 1);

        // Reset in the middle of WAIT, with a fresh A request pending across it.
        no_done = 1'b1;
        d = rnd64();
        data_a = d; req_a = 1'b1;
        expect_xfer(1'b0, d, 1);
        wait_ack(1'b0);
        req_a = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk({p_data, src, start, ack_a, ack_b, busy, timeout_err} == '0, "async_reset_outputs",
               {p_data[57:0], src, start, ack_a, ack_b, busy, timeout_err}, 64'd0);
        m_last_b = 1'b1; m_data = '0; m_src = 1'b0; exp_err = 1'b0;
        d = rnd64();
        data_a = d; req_a = 1'b1;
        shift_delay = 2;
        no_done = 1'b0;
        @(negedge clk);
        expect_xfer(1'b0, d, -1);
        #2 rst = 1'b1;
        wait_ack(1'b0);
        req_a = 1'b0;
        wait_idle();
        do_both(rnd64(), rnd64(), 2);
        do_refresh(3);

        repeat (5) @(negedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
